gps_baseband_bus_if: RTL and testbench

Parametrised Wishbone register front-end for an N-channel GPS baseband. It sits between the MCU Wishbone bus and the time base plus the `tracking_channel` instances. It decodes per-channel and global registers, and broadcasts channel writes on a shared strobe bus. On each channel dump it latches that channel's six correlator accumulators into coherent shadow registers. It maintains the read-to-clear status and new-data words and the `accum_int` interrupt, including overrun detection.

---
 rtl/gps_baseband_bus_if_if.sv | 22 ++
 rtl/gps_baseband_bus_if.sv | 200 ++++++++++++++++++++
 tb/tb_gps_baseband_bus_if.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gps_baseband_bus_if_if.sv
// Wishbone classic bus bundle between the MCU and the GPS baseband register front-end.
// The master modport drives the requests; the slave modport returns the read data and ack.
interface gps_baseband_bus_if_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/gps_baseband_bus_if.sv
// Wishbone register front-end for an N-channel GPS baseband: channel write broadcast,
// coherent correlator shadows, read-to-clear status/new-data and the accum_int interrupt.
// Optional scratch RAM at words 0xD0-0xD7 when BB_TEST_MEM_EN is defined.
module gps_baseband_bus_if #(
    parameter int NUM_CH = 4,
    parameter int ACC_W  = 16
) (
    input  logic                      clk,
    input  logic                      hw_rst,
    gps_baseband_bus_if_if.slave      wb,
    input  logic                      tic_enable,
    input  logic                      accum_enable,
    input  logic [NUM_CH-1:0]         ch_dump,
    input  logic [NUM_CH*6*ACC_W-1:0] ch_acc,
    output logic [NUM_CH-1:0]         ch_wr_stb,
    output logic [3:0]                ch_wr_reg,
    output logic [31:0]               ch_wr_data,
    output logic [23:0]               prog_tic,
    output logic [23:0]               prog_accum_int,
    output logic                      sw_rst,
    output logic                      accum_int
);

    logic [7:0]  word;
    logic [3:0]  ch_idx;
    logic [3:0]  reg_idx;
    logic        accept;
    logic        do_wr;
    logic        do_rd;
    logic [NUM_CH-1:0] ch_hit;
    logic        reg_wr_ok;
    logic        sw_rst_fire;
    logic        status_rd;
    logic        new_data_rd;
    logic [31:0] rd_data;
    logic        unused_bits;

    logic              wb_ack_q,   wb_ack_d;
    logic [31:0]       wb_dat_q,   wb_dat_d;
    logic [NUM_CH-1:0] ch_wr_stb_q, ch_wr_stb_d;
    logic [3:0]        ch_wr_reg_q, ch_wr_reg_d;
    logic [31:0]       ch_wr_data_q, ch_wr_data_d;
    logic [23:0]       prog_tic_q, prog_tic_d;
    logic [23:0]       prog_accum_q, prog_accum_d;
    logic              sw_rst_q,   sw_rst_d;
    logic              accum_int_q, accum_int_d;
    logic [2:0]        status_q,   status_d;
    logic [NUM_CH-1:0] new_data_q, new_data_d;
    logic [ACC_W-1:0]  shadow_q [NUM_CH][6];
    logic [ACC_W-1:0]  shadow_d [NUM_CH][6];

    assign word        = wb.wb_adr_i[9:2];
    assign ch_idx      = word[7:4];
    assign reg_idx     = word[3:0];
    assign accept      = wb.wb_cyc_i & wb.wb_stb_i & ~wb_ack_q;
    assign do_wr       = accept & wb.wb_we_i;
    assign do_rd       = accept & ~wb.wb_we_i;
    assign reg_wr_ok   = (reg_idx <= 4'd3) || (reg_idx == 4'hE);
    assign sw_rst_fire = do_wr && (word == 8'hF0) && wb.wb_dat_i[0];
    assign status_rd   = do_rd && (word == 8'hE0);
    assign new_data_rd = do_rd && (word == 8'hE1);
    assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[31:10], wb.wb_adr_i[1:0]};

    assign wb.wb_ack_o    = wb_ack_q;
    assign wb.wb_dat_o    = wb_dat_q;
    assign ch_wr_stb      = ch_wr_stb_q;
    assign ch_wr_reg      = ch_wr_reg_q;
    assign ch_wr_data     = ch_wr_data_q;
    assign prog_tic       = prog_tic_q;
    assign prog_accum_int = prog_accum_q;
    assign sw_rst         = sw_rst_q;
    assign accum_int      = accum_int_q;

    function automatic logic [31:0] sign_ext(input logic [ACC_W-1:0] v);
        return 32'($signed(v));
    endfunction

    // Channel decode: a one-hot hit only exists for channels that are actually built.
    always_comb begin
        ch_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_hit[i] = (ch_idx == 4'(i));
        end
    end

`ifdef BB_TEST_MEM_EN
    logic [31:0] mem_q [8];
    logic        mem_wr;

    assign mem_wr = do_wr && (word[7:3] == 5'h1A);

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem_q[word[2:0]] <= wb.wb_dat_i;
        end
    end
`endif

    // Read mux reflects state before this edge, so a coincident dump is seen on the next read.
    always_comb begin
        rd_data = '0;
        if (|ch_hit) begin
            for (int i = 0; i < NUM_CH; i++) begin
                for (int k = 0; k < 6; k++) begin
                    if (ch_hit[i] && (reg_idx == 4'(k + 4))) begin
                        rd_data = sign_ext(shadow_q[i][k]);
                    end
                end
            end
        end else begin
            case (word)
                8'hE0:   rd_data = {29'b0, status_q};
                8'hE1:   rd_data[NUM_CH-1:0] = new_data_q;
                8'hE2:   rd_data = {8'b0, prog_tic_q};
                8'hE3:   rd_data = {8'b0, prog_accum_q};
                default: rd_data = '0;
            endcase
`ifdef BB_TEST_MEM_EN
            if (word[7:3] == 5'h1A) begin
                rd_data = mem_q[word[2:0]];
            end
`endif
        end
    end

    always_comb begin
        wb_ack_d     = accept;
        wb_dat_d     = do_rd ? rd_data : '0;
        ch_wr_stb_d  = '0;
        ch_wr_reg_d  = '0;
        ch_wr_data_d = '0;
        if (do_wr && reg_wr_ok && (|ch_hit)) begin
            ch_wr_stb_d  = ch_hit;
            ch_wr_reg_d  = reg_idx;
            ch_wr_data_d = wb.wb_dat_i;
        end
        sw_rst_d     = sw_rst_fire;
        prog_tic_d   = (do_wr && (word == 8'hF1)) ? wb.wb_dat_i[23:0] : prog_tic_q;
        prog_accum_d = (do_wr && (word == 8'hF2)) ? wb.wb_dat_i[23:0] : prog_accum_q;
    end

    // Event state: a pulse on the clearing edge survives the read-to-clear.
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_dump[i]) begin
                for (int k = 0; k < 6; k++) begin
                    shadow_d[i][k] = ch_acc[(i*6+k)*ACC_W +: ACC_W];
                end
            end
        end
        new_data_d = new_data_rd ? ch_dump : (new_data_q | ch_dump);
        if (status_rd) begin
            status_d    = {1'b0, accum_enable, tic_enable};
            accum_int_d = accum_enable;
        end else begin
            status_d    = {status_q[2] | (accum_enable & accum_int_q),
                           status_q[1] | accum_enable,
                           status_q[0] | tic_enable};
            accum_int_d = accum_int_q | accum_enable;
        end
        if (sw_rst_fire) begin
            shadow_d    = '{default: '0};
            new_data_d  = '0;
            status_d    = '0;
            accum_int_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge hw_rst) begin
        if (hw_rst) begin
            wb_ack_q     <= 1'b0;
            wb_dat_q     <= '0;
            ch_wr_stb_q  <= '0;
            ch_wr_reg_q  <= '0;
            ch_wr_data_q <= '0;
            prog_tic_q   <= '0;
            prog_accum_q <= '0;
            sw_rst_q     <= 1'b0;
            accum_int_q  <= 1'b0;
            status_q     <= '0;
            new_data_q   <= '0;
            shadow_q     <= '{default: '0};
        end else begin
            wb_ack_q     <= wb_ack_d;
            wb_dat_q     <= wb_dat_d;
            ch_wr_stb_q  <= ch_wr_stb_d;
            ch_wr_reg_q  <= ch_wr_reg_d;
            ch_wr_data_q <= ch_wr_data_d;
            prog_tic_q   <= prog_tic_d;
            prog_accum_q <= prog_accum_d;
            sw_rst_q     <= sw_rst_d;
            accum_int_q  <= accum_int_d;
            status_q     <= status_d;
            new_data_q   <= new_data_d;
            shadow_q     <= shadow_d;
        end
    end

endmodule

// File: tb/tb_gps_baseband_bus_if.sv
// Scoreboard bench for gps_baseband_bus_if: directed scenarios followed by randomized traffic,
// checked against a transaction-level register model (BB_TEST_MEM_EN selects the scratch RAM).
module tb_gps_baseband_bus_if;
    localparam int NUM_CH = 4;
    localparam int ACC_W  = 16;

    typedef struct {
        bit                is_rd;
        logic [31:0]       data;
        logic [NUM_CH-1:0] stb;
        logic [3:0]        rg;
        logic [31:0]       wdata;
        bit                swrst;
    } txn_t;

    logic                      clk;
    logic                      hw_rst;
    logic                      tic_enable;
    logic                      accum_enable;
    logic [NUM_CH-1:0]         ch_dump;
    logic [NUM_CH*6*ACC_W-1:0] ch_acc;
    logic [NUM_CH-1:0]         ch_wr_stb;
    logic [3:0]                ch_wr_reg;
    logic [31:0]               ch_wr_data;
    logic [23:0]               prog_tic;
    logic [23:0]               prog_accum_int;
    logic                      sw_rst;
    logic                      accum_int;

    gps_baseband_bus_if_if wb_bus ();

    gps_baseband_bus_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) dut (
        .clk            (clk),
        .hw_rst         (hw_rst),
        .wb             (wb_bus),
        .tic_enable     (tic_enable),
        .accum_enable   (accum_enable),
        .ch_dump        (ch_dump),
        .ch_acc         (ch_acc),
        .ch_wr_stb      (ch_wr_stb),
        .ch_wr_reg      (ch_wr_reg),
        .ch_wr_data     (ch_wr_data),
        .prog_tic       (prog_tic),
        .prog_accum_int (prog_accum_int),
        .sw_rst         (sw_rst),
        .accum_int      (accum_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    txn_t sb_q[$];

    // Stimulus state for the current cycle.
    bit                rnd_mode = 1'b0;
    bit                cur_req, cur_we, ev_tic, ev_acc;
    logic [7:0]        cur_word;
    logic [31:0]       cur_dat;
    logic [NUM_CH-1:0] ev_dump;
    logic [ACC_W-1:0]  acc_vals [NUM_CH][6];

    // Register model, advanced once per rising edge.
    logic [31:0]       m_shadow [NUM_CH][6];
    logic [NUM_CH-1:0] m_new;
    bit                m_tic, m_accf, m_ovr, m_int, m_ack;
    logic [23:0]       m_ptic, m_pacc;
    logic [31:0]       m_mem [8];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] sext_model(input logic [ACC_W-1:0] v);
        longint x;
        x = longint'(v);
        if (v[ACC_W-1]) x = x - (longint'(1) << ACC_W);
        return x[31:0];
    endfunction

    task automatic model_step();
        int   c, r;
        bit   accept, st_rd, nd_rd, sw;
        txn_t t;
        c = int'(cur_word) / 16;
        r = int'(cur_word) % 16;
        accept = cur_req && !m_ack;
        if (accept) begin
            t = '{is_rd: !cur_we, data: 32'h0, stb: '0, rg: 4'h0, wdata: 32'h0, swrst: 1'b0};
            if (!cur_we) begin
                if (c < NUM_CH) begin
                    if (r >= 4 && r <= 9) t.data = m_shadow[c][r-4];
                end else if (cur_word == 8'hE0) t.data = {29'b0, m_ovr, m_accf, m_tic};
                else if (cur_word == 8'hE1) t.data = 32'(m_new);
                else if (cur_word == 8'hE2) t.data = {8'b0, m_ptic};
                else if (cur_word == 8'hE3) t.data = {8'b0, m_pacc};
`ifdef BB_TEST_MEM_EN
                else if (cur_word >= 8'hD0 && cur_word <= 8'hD7) t.data = m_mem[cur_word - 8'hD0];
`endif
            end else begin
                if (c < NUM_CH && (r <= 3 || r == 14)) begin
                    t.stb   = NUM_CH'(1 << c);
                    t.rg    = 4'(r);
                    t.wdata = cur_dat;
                end
                t.swrst = (cur_word == 8'hF0) && cur_dat[0];
            end
            sb_q.push_back(t);
        end
        st_rd = accept && !cur_we && cur_word == 8'hE0;
        nd_rd = accept && !cur_we && cur_word == 8'hE1;
        sw    = accept && cur_we && cur_word == 8'hF0 && cur_dat[0];
        for (int i = 0; i < NUM_CH; i++)
            if (ev_dump[i]) for (int k = 0; k < 6; k++) m_shadow[i][k] = sext_model(acc_vals[i][k]);
        m_new = nd_rd ? ev_dump : (m_new | ev_dump);
        if (st_rd) begin
            m_ovr = 0; m_accf = ev_acc; m_tic = ev_tic; m_int = ev_acc;
        end else begin
            if (ev_acc && m_int) m_ovr = 1;
            if (ev_acc) begin m_accf = 1; m_int = 1; end
            if (ev_tic) m_tic = 1;
        end
        if (sw) begin
            m_shadow = '{default: '0};
            m_new = '0; m_ovr = 0; m_accf = 0; m_tic = 0; m_int = 0;
        end
        if (accept && cur_we && cur_word == 8'hF1) m_ptic = cur_dat[23:0];
        if (accept && cur_we && cur_word == 8'hF2) m_pacc = cur_dat[23:0];
        if (accept && cur_we && cur_word >= 8'hD0 && cur_word <= 8'hD7) m_mem[cur_word - 8'hD0] = cur_dat;
        m_ack = accept;
    endtask

    task automatic check_output();
        check("accum_int", 32'(accum_int), 32'(m_int));
        check("prog_tic", 32'(prog_tic), 32'(m_ptic));
        check("prog_accum_int", 32'(prog_accum_int), 32'(m_pacc));
    endtask

    task automatic apply_stimulus(input bit req, input bit we, input logic [7:0] word, input logic [31:0] dat);
        if (rnd_mode) begin
            ev_tic = ($urandom_range(0, 7) == 0);
            ev_acc = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < NUM_CH; i++) begin
                ev_dump[i] = ($urandom_range(0, 4) == 0);
                for (int k = 0; k < 6; k++) acc_vals[i][k] = ACC_W'($urandom);
            end
        end
        cur_req = req; cur_we = we; cur_word = word; cur_dat = dat;
        wb_bus.wb_cyc_i = req;
        wb_bus.wb_stb_i = req;
        wb_bus.wb_we_i  = we;
        wb_bus.wb_adr_i = {22'b0, word, 2'b00};
        wb_bus.wb_dat_i = dat;
        wb_bus.wb_sel_i = 4'hF;
        tic_enable   = ev_tic;
        accum_enable = ev_acc;
        ch_dump      = ev_dump;
        for (int i = 0; i < NUM_CH; i++)
            for (int k = 0; k < 6; k++) ch_acc[(i*6+k)*ACC_W +: ACC_W] = acc_vals[i][k];
        @(posedge clk);
        model_step();
        #1;
        check_output();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 8'h00, 32'h0);
    endtask

    task automatic bus_write(input logic [7:0] word, input logic [31:0] dat);
        apply_stimulus(1, 1, word, dat);
        apply_stimulus(0, 0, 8'h00, 32'h0);
    endtask

    task automatic bus_read(input logic [7:0] word);
        apply_stimulus(1, 0, word, 32'h0);
        apply_stimulus(0, 0, 8'h00, 32'h0);
    endtask

    // Monitor: every ack pops one expected response; outside ack the pulse outputs must be low.
    always @(negedge clk) begin
        txn_t t;
        if (!hw_rst) begin
            if (wb_bus.wb_ack_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ack", 32'(wb_bus.wb_ack_o), 32'h0);
                end else begin
                    t = sb_q.pop_front();
                    if (t.is_rd) begin
                        check("rd_data", wb_bus.wb_dat_o, t.data);
                    end else begin
                        check("wr_stb", 32'(ch_wr_stb), 32'(t.stb));
                        check("sw_rst", 32'(sw_rst), 32'(t.swrst));
                        if (t.stb != '0) begin
                            check("wr_reg", 32'(ch_wr_reg), 32'(t.rg));
                            check("wr_data", ch_wr_data, t.wdata);
                        end
                    end
                end
            end else begin
                check("idle_stb", 32'(ch_wr_stb), 32'h0);
                check("idle_sw_rst", 32'(sw_rst), 32'h0);
            end
        end
    end

    initial begin
        logic [7:0]  w;
        logic [31:0] d;
        hw_rst = 1'b1;
        ev_tic = 0; ev_acc = 0; ev_dump = '0;
        acc_vals = '{default: '0};
        m_shadow = '{default: '0};
        m_mem = '{default: '0};
        m_new = '0; m_tic = 0; m_accf = 0; m_ovr = 0; m_int = 0; m_ack = 0;
        m_ptic = '0; m_pacc = '0;
        cur_req = 0; cur_we = 0; cur_word = '0; cur_dat = '0;
        wb_bus.wb_cyc_i = 0; wb_bus.wb_stb_i = 0; wb_bus.wb_we_i = 0;
        wb_bus.wb_adr_i = '0; wb_bus.wb_dat_i = '0; wb_bus.wb_sel_i = '0;
        tic_enable = 0; accum_enable = 0; ch_dump = '0; ch_acc = '0;
        repeat (3) @(negedge clk);
        hw_rst = 1'b0;
        idle(5);
        check("rst_ack", 32'(wb_bus.wb_ack_o), 32'h0);
        check("rst_dat", wb_bus.wb_dat_o, 32'h0);
        check("rst_stb", 32'(ch_wr_stb), 32'h0);
        check("rst_reg", 32'(ch_wr_reg), 32'h0);
        check("rst_wdata", ch_wr_data, 32'h0);
        check("rst_sw_rst", 32'(sw_rst), 32'h0);
        bus_read(8'hE1);

        // Channel write broadcast, then a write to an unbuilt channel.
        bus_write(8'h21, 32'h0123_4567);
        bus_write(8'h41, 32'h0123_4567);
        bus_write(8'h25, 32'hAAAA_5555);

        // Shadow latch with a negative IP, then the live accumulator moves on.
        acc_vals[1][2] = 16'hFFF0;
        ev_dump = 4'b0010;
        idle(1);
        ev_dump = '0;
        acc_vals[1][2] = 16'h1234;
        idle(2);
        bus_read(8'h16);
        bus_read(8'h1A);

        // Dump coincident with the NEW_DATA read.
        ev_dump = 4'b0001;
        apply_stimulus(1, 0, 8'hE1, 32'h0);
        ev_dump = '0;
        idle(1);
        bus_read(8'hE1);

        // Two accum pulses without a STATUS read give accum plus overrun.
        ev_acc = 1; idle(1); ev_acc = 0; idle(2);
        ev_acc = 1; idle(1); ev_acc = 0; idle(1);
        bus_read(8'hE0);
        bus_read(8'hE0);

        // Programmed dividers survive a software reset; shadows and new_data do not.
        bus_write(8'hF1, 32'hFFAB_CDEF);
        bus_write(8'hF2, 32'h0012_3456);
        ev_dump = 4'b1010; idle(1); ev_dump = '0;
        bus_write(8'hF0, 32'h0000_0001);
        bus_read(8'hE2);
        bus_read(8'hE3);
        bus_read(8'hE1);
        bus_read(8'h16);

        // Scratch RAM window.
        bus_write(8'hD3, 32'hDEAD_BEEF);
        bus_read(8'hD3);

        // Master holding stb across the ack cycle gets a second accept.
        for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 8'hE2, 32'h0);
        idle(2);

        // Randomized traffic with random events.
        rnd_mode = 1'b1;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    w = 8'(($urandom_range(0, NUM_CH + 1) << 4) | $urandom_range(0, 15));
                2:       w = 8'(8'hE0 + $urandom_range(0, 3));
                3:       w = 8'(8'hF0 + $urandom_range(0, 2));
                4:       w = 8'(8'hD0 + $urandom_range(0, 7));
                default: w = 8'($urandom_range(0, 255));
            endcase
            d = $urandom;
            if (w == 8'hF0) d[0] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) bus_write(w, d);
            else bus_read(w);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rnd_mode = 1'b0;
        ev_tic = 0; ev_acc = 0; ev_dump = '0;
        idle(4);
        check("pending_responses", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
